// File: rtl/mem_pkg.sv
// Op codes, access sizes, FSM states, bus payload and decode helpers shared by the MEM-stage
// data-memory access unit and its load aligner.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_OP_W   = 4;

  localparam logic [MEM_OP_W-1:0] MOP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MOP_LB   = 4'd1;
  localparam logic [MEM_OP_W-1:0] MOP_LBU  = 4'd2;
  localparam logic [MEM_OP_W-1:0] MOP_LH   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MOP_LHU  = 4'd4;
  localparam logic [MEM_OP_W-1:0] MOP_LW   = 4'd5;
  localparam logic [MEM_OP_W-1:0] MOP_SB   = 4'd6;
  localparam logic [MEM_OP_W-1:0] MOP_SH   = 4'd7;
  localparam logic [MEM_OP_W-1:0] MOP_SW   = 4'd8;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic                  wr;
    logic [1:0]            size;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [3:0]            wstrb;
  } mem_req_t;

  function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
    return op inside {MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW};
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
    return op inside {MOP_SB, MOP_SH, MOP_SW};
  endfunction

  function automatic logic [1:0] op_size(input logic [MEM_OP_W-1:0] op);
    logic [1:0] size;
    size = SIZE_BYTE;
    if (op inside {MOP_LH, MOP_LHU, MOP_SH}) size = SIZE_HALF;
    if (op inside {MOP_LW, MOP_SW})          size = SIZE_WORD;
    return size;
  endfunction

  // Byte lane of the access with the low address bits forced to natural alignment.
  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lo);
    logic [1:0] lane;
    lane = lo;
    if (size == SIZE_HALF) lane = {lo[1], 1'b0};
    if (size == SIZE_WORD) lane = 2'b00;
    return lane;
  endfunction

  function automatic logic op_misaligned(input logic [MEM_OP_W-1:0] op, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    if (op_size(op) == SIZE_HALF) mis = lo[0];
    if (op_size(op) == SIZE_WORD) mis = |lo;
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data aligner: picks the addressed byte/half lane (little-endian) of the read word and
// sign- or zero-extends it according to the load op.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [MEM_OP_W-1:0]   op,
  input  logic [1:0]            lane,
  input  logic [MEM_DATA_W-1:0] rdata,
  output logic [MEM_DATA_W-1:0] load_data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c      = rdata[7:0];
    half_c      = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data_c = '0;
    case (lane)
      2'd1:    byte_c = rdata[15:8];
      2'd2:    byte_c = rdata[23:16];
      2'd3:    byte_c = rdata[31:24];
      default: byte_c = rdata[7:0];
    endcase
    case (op)
      MOP_LB:  load_data_c = {{24{byte_c[7]}}, byte_c};
      MOP_LBU: load_data_c = {24'd0, byte_c};
      MOP_LH:  load_data_c = {{16{half_c[15]}}, half_c};
      MOP_LHU: load_data_c = {16'd0, half_c};
      MOP_LW:  load_data_c = rdata;
      default: load_data_c = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: issues one SRAM-like bus transaction per memory op and holds the
// pipe until it completes. Option MEM_UNALIGNED_EXC_EN turns misaligned accesses into o_adel/o_ades.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MEM_OP_W-1:0] i_op,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [31:0]         i_alu_result,
  input  logic [4:0]          i_rn,
  input  logic                i_write_regfile,
  input  logic                i_stall_ext,
  output logic [31:0]         o_d1,
  output logic [DATA_W-1:0]   o_d2,
  output logic [4:0]          o_rn,
  output logic                o_write_regfile,
  output logic                o_mem_to_regfile,
  output logic                o_stall_req,
`ifdef MEM_UNALIGNED_EXC_EN
  output logic                o_adel,
  output logic                o_ades,
`endif
  output logic                data_req,
  output logic                data_wr,
  output logic [1:0]          data_size,
  output logic [ADDR_W-1:0]   data_addr,
  output logic [DATA_W-1:0]   data_wdata,
  output logic [3:0]          data_wstrb,
  input  logic                data_addr_ok,
  input  logic                data_data_ok,
  input  logic [DATA_W-1:0]   data_rdata
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic              is_load, is_store, mem_op, addr_exc;
  logic [1:0]        size, lane;
  logic [DATA_W-1:0] align_data_c;
  mem_req_t          req_c;

  // Op decode; lane is the byte offset actually presented to the bus and the aligner.
  always_comb begin
    is_load  = op_is_load(i_op);
    is_store = op_is_store(i_op);
    mem_op   = is_load | is_store;
    size     = op_size(i_op);
`ifdef MEM_UNALIGNED_EXC_EN
    addr_exc = mem_op & op_misaligned(i_op, i_addr[1:0]);
    lane     = i_addr[1:0];
`else
    addr_exc = 1'b0;
    lane     = align_lane(size, i_addr[1:0]);
`endif
  end

  // Bus payload: store data replicated across every lane, strobes select the written bytes.
  always_comb begin
    req_c.wr    = is_store;
    req_c.size  = size;
    req_c.addr  = {i_addr[ADDR_W-1:2], lane};
    req_c.wdata = i_wdata;
    req_c.wstrb = 4'b0000;
    case (size)
      SIZE_BYTE: req_c.wdata = {4{i_wdata[7:0]}};
      SIZE_HALF: req_c.wdata = {2{i_wdata[15:0]}};
      default:   req_c.wdata = i_wdata;
    endcase
    if (is_store) begin
      case (size)
        SIZE_BYTE: req_c.wstrb = 4'b0001 << lane;
        SIZE_HALF: req_c.wstrb = lane[1] ? 4'b1100 : 4'b0011;
        default:   req_c.wstrb = 4'b1111;
      endcase
    end
  end

  mem_load_align u_load_align (
    .op          (i_op),
    .lane        (lane),
    .rdata       (data_rdata),
    .load_data_c (align_data_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  // Next state and outputs; data_ok is only honoured once the request has been accepted.
  always_comb begin
    state_d          = state_q;
    load_d           = load_q;
    data_req         = 1'b0;
    data_wr          = req_c.wr;
    data_size        = req_c.size;
    data_addr        = req_c.addr;
    data_wdata       = req_c.wdata;
    data_wstrb       = req_c.wstrb;
    o_d1             = i_alu_result;
    o_d2             = is_load ? load_q : '0;
    o_rn             = i_rn;
    o_write_regfile  = i_write_regfile & ~addr_exc;
    o_mem_to_regfile = is_load;
    o_stall_req      = mem_op && (state_q != ST_DONE);
`ifdef MEM_UNALIGNED_EXC_EN
    o_adel           = 1'b0;
    o_ades           = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_op) state_d = addr_exc ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        data_req = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d = ST_DONE;
            load_d  = align_data_c;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          state_d = ST_DONE;
          load_d  = align_data_c;
        end
      end
      ST_DONE: begin
`ifdef MEM_UNALIGNED_EXC_EN
        o_adel = addr_exc & is_load;
        o_ades = addr_exc & is_store;
`endif
        if (!i_stall_ext) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed and randomized load/store/pass-through ops
// against a byte-lane reference model and a responder with programmable addr_ok/data_ok delays.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  i_op;
  logic [31:0] i_addr, i_wdata, i_alu_result;
  logic [4:0]  i_rn;
  logic        i_write_regfile, i_stall_ext;
  logic [31:0] o_d1, o_d2;
  logic [4:0]  o_rn;
  logic        o_write_regfile, o_mem_to_regfile, o_stall_req;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] rand_ops [8] = '{MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW, MOP_SB, MOP_SH, MOP_SW};

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .i_op(i_op), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_alu_result(i_alu_result), .i_rn(i_rn), .i_write_regfile(i_write_regfile),
    .i_stall_ext(i_stall_ext), .o_d1(o_d1), .o_d2(o_d2), .o_rn(o_rn),
    .o_write_regfile(o_write_regfile), .o_mem_to_regfile(o_mem_to_regfile),
    .o_stall_req(o_stall_req), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, want);
    end
  endtask

  function automatic int nbytes(input logic [3:0] op);
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: return 1;
      MOP_LH, MOP_LHU, MOP_SH: return 2;
      MOP_LW, MOP_SW:          return 4;
      default:                 return 0;
    endcase
  endfunction

  // Reference load result: pick bytes at the aligned offset and extend per op.
  function automatic logic [31:0] ref_load(input logic [3:0] op, input int off, input logic [31:0] rd);
    byte     sb;
    shortint sh;
    case (op)
      MOP_LB:  begin sb = rd[8*off +: 8];  return 32'(int'(sb)); end
      MOP_LBU: return {24'd0, rd[8*off +: 8]};
      MOP_LH:  begin sh = rd[8*off +: 16]; return 32'(int'(sh)); end
      MOP_LHU: return {16'd0, rd[8*off +: 16]};
      MOP_LW:  return rd;
      default: return 32'd0;
    endcase
  endfunction

  // One load/store: entered on a negedge, returns on the negedge after the op leaves DONE.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int a_dly, input int d_dly,
                        input int hold, input bit stray);
    int          nb, off, stalls, reqs, waited, after;
    bit          is_ld, is_st, accepted, done;
    logic [31:0] exp_addr, exp_wd, exp_d2, alu;
    logic [3:0]  exp_strb;
    logic [4:0]  rn;
    logic        wreg;
    nb       = nbytes(op);
    is_st    = op inside {MOP_SB, MOP_SH, MOP_SW};
    is_ld    = !is_st;
    exp_addr = addr - (addr % 32'(nb));
    off      = int'(exp_addr[1:0]);
    exp_strb = is_st ? 4'(((1 << nb) - 1) << off) : 4'd0;
    for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = wdata[8*(b % nb) +: 8];
    exp_d2   = ref_load(op, off, rdata);
    alu      = $urandom;
    rn       = 5'($urandom);
    wreg     = 1'($urandom);
    i_op = op; i_addr = addr; i_wdata = wdata; i_alu_result = alu; i_rn = rn;
    i_write_regfile = wreg; i_stall_ext = 1'b0;
    stalls = 0; reqs = 0; waited = 0; after = 0; accepted = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      #1;
      if (!o_stall_req) begin
        done = 1;
      end else begin
        stalls++;
        if (c == 0 && stray) data_data_ok = 1'b1;
        if (data_req) begin
          reqs++;
          check("req_addr", data_addr, exp_addr);
          check("req_wr", 32'(data_wr), 32'(is_st));
          check("req_size", 32'(data_size), 32'($clog2(nb)));
          check("req_wstrb", 32'(data_wstrb), 32'(exp_strb));
          if (is_st) check("req_wdata", data_wdata, exp_wd);
          if (!accepted) begin
            if (waited == a_dly) begin
              data_addr_ok = 1'b1; accepted = 1;
              if (d_dly == 0) begin data_data_ok = 1'b1; data_rdata = rdata; end
            end else begin
              waited++;
            end
          end
        end else if (accepted) begin
          after++;
          if (after == d_dly) begin data_data_ok = 1'b1; data_rdata = rdata; end
        end
        @(negedge clk);
      end
    end
    n_cmp++;
    assert (done) else begin
      n_err++;
      $error("FAIL timeout: observed no completion expected stall release within 40 cycles");
    end
    check("stall_cycles", 32'(stalls), 32'(a_dly + d_dly + 2));
    check("req_cycles", 32'(reqs), 32'(a_dly + 1));
    check("d2", o_d2, exp_d2);
    check("mem_to_rf", 32'(o_mem_to_regfile), 32'(is_ld));
    check("d1", o_d1, alu);
    check("rn", 32'(o_rn), 32'(rn));
    check("write_rf", 32'(o_write_regfile), 32'(wreg));
    check("req_in_done", 32'(data_req), 32'd0);
    for (int h = 0; h < hold; h++) begin
      i_stall_ext = 1'b1; data_data_ok = 1'($urandom); data_rdata = $urandom;
      @(negedge clk); #1;
      check("hold_stall", 32'(o_stall_req), 32'd0);
      check("hold_req", 32'(data_req), 32'd0);
      check("hold_d2", o_d2, exp_d2);
    end
    i_stall_ext = 1'b0; data_data_ok = 1'b0; data_addr_ok = 1'b0;
    @(negedge clk);
  endtask

  // Pass-through op: no stall, no request, outputs follow inputs in the same cycle.
  task automatic run_none();
    logic [31:0] alu;
    logic [4:0]  rn;
    logic        wreg;
    alu = $urandom; rn = 5'($urandom); wreg = 1'($urandom);
    i_op = MOP_NONE; i_addr = $urandom; i_alu_result = alu; i_rn = rn; i_write_regfile = wreg;
    data_addr_ok = 1'b0; data_data_ok = 1'($urandom); data_rdata = $urandom;
    #1;
    check("none_stall", 32'(o_stall_req), 32'd0);
    check("none_req", 32'(data_req), 32'd0);
    check("none_d1", o_d1, alu);
    check("none_d2", o_d2, 32'd0);
    check("none_rn", 32'(o_rn), 32'(rn));
    check("none_write_rf", 32'(o_write_regfile), 32'(wreg));
    check("none_mem_to_rf", 32'(o_mem_to_regfile), 32'd0);
    @(negedge clk);
    data_data_ok = 1'b0;
  endtask

  initial begin
    reset = 1'b0; i_op = MOP_NONE; i_addr = '0; i_wdata = '0; i_alu_result = '0; i_rn = '0;
    i_write_regfile = 1'b0; i_stall_ext = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    @(negedge clk); #1;
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_stall", 32'(o_stall_req), 32'd0);
    i_op = MOP_LW; #1;
    check("rst_d2", o_d2, 32'd0);
    i_op = MOP_NONE;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    run_op(MOP_LW,  32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0);
    run_op(MOP_LB,  32'h0000_0103, 32'h0,         32'h8011_2233, 0, 0, 0, 0);
    run_op(MOP_LBU, 32'h0000_0103, 32'h0,         32'h8011_2233, 0, 0, 0, 0);
    run_op(MOP_SH,  32'h0000_0202, 32'h0000_ABCD, 32'h0,         0, 0, 0, 0);
    run_op(MOP_LW,  32'h0000_0104, 32'h0,         32'h1357_9BDF, 3, 2, 0, 0);
    run_op(MOP_LH,  32'h0000_0012, 32'h0,         32'h8001_7FFF, 1, 1, 2, 0);
    run_op(MOP_SB,  32'h0000_0021, 32'h0000_005A, 32'h0,         0, 1, 0, 1);
    run_none();

    // Reset while the response is outstanding, then a stray data_ok once idle.
    i_op = MOP_LW; i_addr = 32'h0000_0300; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    @(negedge clk); #1;
    check("wait_setup_req", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    @(negedge clk); data_addr_ok = 1'b0; #1;
    check("wait_req_low", 32'(data_req), 32'd0);
    check("wait_stall", 32'(o_stall_req), 32'd1);
    reset = 1'b0; i_op = MOP_NONE; #1;
    check("rst_wait_req", 32'(data_req), 32'd0);
    check("rst_wait_stall", 32'(o_stall_req), 32'd0);
    @(negedge clk); reset = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    @(negedge clk); data_data_ok = 1'b0; i_op = MOP_LW; i_addr = 32'h0000_0300; #1;
    check("stray_d2", o_d2, 32'd0);
    check("stray_req", 32'(data_req), 32'd0);
    i_op = MOP_NONE;
    @(negedge clk);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) run_none();
      else run_op(rand_ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
